// File: rtl/axis_host_endpoint.sv
// Host-side AXI-Stream endpoint: TX FIFO that injects host vectors as MVM input-vector flits,
// and an RX FIFO that collects result flits for the host to read in show-ahead fashion.

module axis_host_endpoint_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // Admission uses the pre-edge flags, so a full FIFO refuses a push even while it pops.
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
      if (do_pop)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
      case ({do_push, do_pop})
         2'b10:   count_d = CW'(count_q + 1'b1);
         2'b01:   count_d = CW'(count_q - 1'b1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left unreset; the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

module axis_host_endpoint #(
   parameter int unsigned DATAW      = 512,
   parameter int unsigned USERW      = 75,
   parameter int unsigned IDW        = 2,
   parameter int unsigned DESTW      = 4,
   parameter int unsigned DESTNODE   = 0,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   disp_fifo_wen,
   input  logic [DATAW-1:0]       disp_fifo_wdata,
   input  logic                   disp_last,
   output logic                   disp_fifo_rdy,
   output logic                   axis_tx_tvalid,
   input  logic                   axis_tx_tready,
   output logic [USERW+DATAW-1:0] axis_tx_tdata,
   output logic [IDW-1:0]         axis_tx_tid,
   output logic [DESTW-1:0]       axis_tx_tdest,
   output logic                   axis_tx_tlast,
   input  logic                   axis_rx_tvalid,
   input  logic [DATAW-1:0]       axis_rx_tdata,
   input  logic [IDW-1:0]         axis_rx_tid,
   input  logic [DESTW-1:0]       axis_rx_tdest,
   output logic                   axis_rx_tready,
   input  logic                   coll_fifo_ren,
   output logic [DATAW-1:0]       coll_fifo_rdata,
   output logic                   coll_fifo_rdy
);
   localparam int unsigned TXW = DATAW + 1;
   // rf_addr = 0, opcode 2'b01 (input vector), remaining header bits zero.
   localparam logic [USERW-1:0] TX_HDR = USERW'({2'b01, 9'd0});

   logic [TXW-1:0]   tx_head;
   logic             tx_full, tx_empty;
   logic             rx_full, rx_empty;
   logic [USERW-1:0] tx_hdr;
   logic             unused_rx_side;

   axis_host_endpoint_fifo #(.W(TXW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (disp_fifo_wen),
      .pop_i   (axis_tx_tready),
      .wdata_i ({disp_last, disp_fifo_wdata}),
      .rdata_o (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   axis_host_endpoint_fifo #(.W(DATAW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (axis_rx_tvalid),
      .pop_i   (coll_fifo_ren),
      .wdata_i (axis_rx_tdata),
      .rdata_o (coll_fifo_rdata),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   // Ready flags are forced low for the whole time reset is held.
   assign disp_fifo_rdy  = !tx_full && !rst;
   assign axis_rx_tready = !rx_full && !rst;

   assign tx_hdr         = tx_empty ? '0 : TX_HDR;
   assign axis_tx_tvalid = !tx_empty;
   assign axis_tx_tdata  = {tx_hdr, tx_head[DATAW-1:0]};
   assign axis_tx_tlast  = tx_head[DATAW];
   assign axis_tx_tid    = '0;
   assign axis_tx_tdest  = DESTW'(DESTNODE);
   assign coll_fifo_rdy  = !rx_empty;

   assign unused_rx_side = ^{axis_rx_tid, axis_rx_tdest};
endmodule

// File: tb/tb_axis_host_endpoint.sv
// Self-checking bench for axis_host_endpoint: queue scoreboard per direction, a vector table,
// and hand-written sequences for backpressure, full/empty push-pop, reset and pointer wrap.
module tb_axis_host_endpoint;
   localparam int unsigned DATAW = 512;
   localparam int unsigned USERW = 75;
   localparam int unsigned IDW   = 2;
   localparam int unsigned DESTW = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned TW    = USERW + DATAW;

   logic clk = 1'b0;
   logic rst;
   logic disp_fifo_wen, disp_last, disp_fifo_rdy;
   logic [DATAW-1:0] disp_fifo_wdata;
   logic axis_tx_tvalid, axis_tx_tready, axis_tx_tlast;
   logic [TW-1:0] axis_tx_tdata;
   logic [IDW-1:0] axis_tx_tid;
   logic [DESTW-1:0] axis_tx_tdest;
   logic axis_rx_tvalid, axis_rx_tready;
   logic [DATAW-1:0] axis_rx_tdata;
   logic [IDW-1:0] axis_rx_tid;
   logic [DESTW-1:0] axis_rx_tdest;
   logic coll_fifo_ren, coll_fifo_rdy;
   logic [DATAW-1:0] coll_fifo_rdata;

   axis_host_endpoint #(.DATAW(DATAW), .USERW(USERW), .IDW(IDW), .DESTW(DESTW),
                        .DESTNODE(2), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .disp_fifo_wen(disp_fifo_wen), .disp_fifo_wdata(disp_fifo_wdata),
      .disp_last(disp_last), .disp_fifo_rdy(disp_fifo_rdy),
      .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tready(axis_tx_tready),
      .axis_tx_tdata(axis_tx_tdata), .axis_tx_tid(axis_tx_tid),
      .axis_tx_tdest(axis_tx_tdest), .axis_tx_tlast(axis_tx_tlast),
      .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tdata(axis_rx_tdata),
      .axis_rx_tid(axis_rx_tid), .axis_rx_tdest(axis_rx_tdest),
      .axis_rx_tready(axis_rx_tready), .coll_fifo_ren(coll_fifo_ren),
      .coll_fifo_rdata(coll_fifo_rdata), .coll_fifo_rdy(coll_fifo_rdy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             wen;
      logic [DATAW-1:0] wdata;
      logic             last;
      logic             tready;
      logic             rxv;
      logic [DATAW-1:0] rxd;
      logic             ren;
      logic             exp_tx_valid;
      logic             exp_coll_rdy;
   } vec_t;

   logic [DATAW:0]   txq[$];
   logic [DATAW-1:0] rxq[$];
   int checks = 0;
   int errors = 0;
   int tx_pops = 0;
   int rx_pops = 0;
   logic [USERW-1:0] exp_hdr;

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      disp_fifo_wen = 0; disp_fifo_wdata = '0; disp_last = 0; axis_tx_tready = 0;
      axis_rx_tvalid = 0; axis_rx_tdata = '0; coll_fifo_ren = 0;
   endtask

   // Compare DUT against the scoreboard, advance the model by one edge, then step the clock.
   task automatic cycle();
      bit tx_full, rx_full;
      chk("tx_tvalid", TW'(axis_tx_tvalid), TW'(txq.size() != 0));
      chk("disp_fifo_rdy", TW'(disp_fifo_rdy), TW'(txq.size() < DEPTH));
      chk("rx_tready", TW'(axis_rx_tready), TW'(rxq.size() < DEPTH));
      chk("coll_fifo_rdy", TW'(coll_fifo_rdy), TW'(rxq.size() != 0));
      if (txq.size() != 0) begin
         chk("tx_tdata", axis_tx_tdata, {exp_hdr, txq[0][DATAW-1:0]});
         chk("tx_tlast", TW'(axis_tx_tlast), TW'(txq[0][DATAW]));
         chk("tx_tdest", TW'(axis_tx_tdest), TW'(2));
         chk("tx_tid", TW'(axis_tx_tid), TW'(0));
      end
      if (rxq.size() != 0) chk("coll_rdata", TW'(coll_fifo_rdata), TW'(rxq[0]));
      tx_full = (txq.size() == DEPTH);
      rx_full = (rxq.size() == DEPTH);
      if (txq.size() != 0 && axis_tx_tready) begin void'(txq.pop_front()); tx_pops++; end
      if (disp_fifo_wen && !tx_full) txq.push_back({disp_last, disp_fifo_wdata});
      if (coll_fifo_ren && rxq.size() != 0) begin void'(rxq.pop_front()); rx_pops++; end
      if (axis_rx_tvalid && !rx_full) rxq.push_back(axis_rx_tdata);
      @(posedge clk); #1;
   endtask

   function automatic logic [DATAW-1:0] rnd_word();
      logic [DATAW-1:0] w;
      for (int k = 0; k < DATAW / 32; k++) w[k*32 +: 32] = $urandom;
      return w;
   endfunction

   vec_t vt[6];

   initial begin
      exp_hdr = '0;
      exp_hdr[10:9] = 2'b01;
      idle_inputs();
      axis_rx_tid = 2'b11; axis_rx_tdest = 4'hF;
      rst = 1;
      #12;
      chk("rst_disp_rdy", TW'(disp_fifo_rdy), TW'(0));
      chk("rst_rx_tready", TW'(axis_rx_tready), TW'(0));
      chk("rst_tx_tvalid", TW'(axis_tx_tvalid), TW'(0));
      chk("rst_coll_rdy", TW'(coll_fifo_rdy), TW'(0));
      @(posedge clk); #1;
      rst = 0;
      #1;
      chk("idle_disp_rdy", TW'(disp_fifo_rdy), TW'(1));
      chk("idle_rx_tready", TW'(axis_rx_tready), TW'(1));
      chk("idle_tdata", axis_tx_tdata, TW'(0));
      cycle();

      // Three TX vectors (last on the third) concurrent with four RX flits drained immediately.
      vt[0] = '{1, DATAW'(1), 0, 1, 1, DATAW'(3),   1, 0, 0};
      vt[1] = '{1, DATAW'(2), 0, 1, 1, DATAW'(6),   1, 1, 1};
      vt[2] = '{1, DATAW'(3), 1, 1, 1, DATAW'(9),   1, 1, 1};
      vt[3] = '{0, DATAW'(0), 0, 1, 1, DATAW'(12),  1, 1, 1};
      vt[4] = '{0, DATAW'(0), 0, 1, 0, DATAW'(0),   1, 0, 1};
      vt[5] = '{0, DATAW'(0), 0, 1, 0, DATAW'(0),   1, 0, 0};
      for (int i = 0; i < 6; i++) begin
         disp_fifo_wen = vt[i].wen; disp_fifo_wdata = vt[i].wdata; disp_last = vt[i].last;
         axis_tx_tready = vt[i].tready; axis_rx_tvalid = vt[i].rxv; axis_rx_tdata = vt[i].rxd;
         coll_fifo_ren = vt[i].ren;
         chk($sformatf("vec%0d_tx_tvalid", i), TW'(axis_tx_tvalid), TW'(vt[i].exp_tx_valid));
         chk($sformatf("vec%0d_coll_rdy", i), TW'(coll_fifo_rdy), TW'(vt[i].exp_coll_rdy));
         cycle();
      end
      chk("vec_tx_count", TW'(tx_pops), TW'(3));
      chk("vec_rx_count", TW'(rx_pops), TW'(4));

      // TX backpressure: nine writes into a stalled FIFO, the ninth must be dropped.
      idle_inputs();
      tx_pops = 0;
      for (int i = 0; i < 9; i++) begin
         disp_fifo_wen = 1; disp_fifo_wdata = DATAW'(100 + i); disp_last = (i == 8);
         cycle();
      end
      chk("tx_full_rdy", TW'(disp_fifo_rdy), TW'(0));
      idle_inputs();
      for (int i = 0; i < 3; i++) cycle();
      axis_tx_tready = 1;
      for (int i = 0; i < 10; i++) cycle();
      chk("tx_drain_count", TW'(tx_pops), TW'(8));

      // RX backpressure: ten flits with no reads, only eight accepted.
      idle_inputs();
      rx_pops = 0;
      for (int i = 0; i < 10; i++) begin
         axis_rx_tvalid = 1; axis_rx_tdata = DATAW'(200 + i);
         cycle();
      end
      chk("rx_full_tready", TW'(axis_rx_tready), TW'(0));
      idle_inputs();
      coll_fifo_ren = 1;
      for (int i = 0; i < 10; i++) cycle();
      chk("rx_drain_count", TW'(rx_pops), TW'(8));
      chk("rx_drain_rdy", TW'(coll_fifo_rdy), TW'(0));

      // Push+pop at full on both FIFOs: pop happens, push is refused.
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) begin
         disp_fifo_wen = 1; disp_fifo_wdata = rnd_word();
         axis_rx_tvalid = 1; axis_rx_tdata = rnd_word();
         cycle();
      end
      disp_fifo_wen = 1; disp_fifo_wdata = DATAW'(777); axis_tx_tready = 1;
      axis_rx_tvalid = 1; axis_rx_tdata = DATAW'(888); coll_fifo_ren = 1;
      cycle();
      chk("full_pp_tx_size", TW'(txq.size()), TW'(DEPTH - 1));
      // Sustained push+pop across many pointer wraps, then random traffic.
      for (int i = 0; i < 40; i++) begin
         disp_fifo_wdata = rnd_word(); disp_last = 1'($urandom);
         axis_rx_tdata = rnd_word();
         cycle();
      end
      for (int i = 0; i < 300; i++) begin
         disp_fifo_wen = 1'($urandom); disp_fifo_wdata = rnd_word(); disp_last = 1'($urandom);
         axis_tx_tready = ($urandom_range(3) != 0);
         axis_rx_tvalid = 1'($urandom); axis_rx_tdata = rnd_word();
         coll_fifo_ren = ($urandom_range(3) != 0);
         cycle();
      end
      // Push+pop at empty: only the push lands.
      idle_inputs();
      axis_tx_tready = 1; coll_fifo_ren = 1;
      for (int i = 0; i < 12; i++) cycle();
      disp_fifo_wen = 1; disp_fifo_wdata = DATAW'(55);
      axis_rx_tvalid = 1; axis_rx_tdata = DATAW'(66);
      cycle();
      idle_inputs();
      chk("empty_pp_tx_size", TW'(txq.size()), TW'(1));
      cycle();

      // Asynchronous reset mid-stream discards everything.
      for (int i = 0; i < 5; i++) begin
         disp_fifo_wen = 1; disp_fifo_wdata = rnd_word();
         axis_rx_tvalid = 1; axis_rx_tdata = rnd_word();
         cycle();
      end
      idle_inputs();
      #2 rst = 1;
      #1;
      chk("mid_rst_tx_tvalid", TW'(axis_tx_tvalid), TW'(0));
      chk("mid_rst_coll_rdy", TW'(coll_fifo_rdy), TW'(0));
      chk("mid_rst_disp_rdy", TW'(disp_fifo_rdy), TW'(0));
      chk("mid_rst_rx_tready", TW'(axis_rx_tready), TW'(0));
      txq.delete();
      rxq.delete();
      @(posedge clk); #1;
      rst = 0;
      #1;
      chk("post_rst_disp_rdy", TW'(disp_fifo_rdy), TW'(1));
      chk("post_rst_rx_tready", TW'(axis_rx_tready), TW'(1));
      for (int i = 0; i < 4; i++) begin
         disp_fifo_wen = (i < 2); disp_fifo_wdata = DATAW'(40 + i); axis_tx_tready = 1;
         axis_rx_tvalid = (i < 2); axis_rx_tdata = DATAW'(50 + i); coll_fifo_ren = 1;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
